// File: rtl/cci_mpf_shim_req_buffer.sv
// Request-side elastic buffer between the ordering shim (AFU side) and the FIU:
// one FIFO per channel, registered FIU outputs. Optional stats: CCI_MPF_REQ_BUF_STATS_EN.

module cci_mpf_shim_req_buffer_chan #(
  parameter int N_ENTRIES          = 8,
  parameter int ALM_FULL_THRESHOLD = 4,
  parameter int REQ_WIDTH          = 80,
  localparam int CW = $clog2(N_ENTRIES) + 1,
  localparam int PW = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [REQ_WIDTH-1:0] in_req,
  output logic                 alm_full,
  output logic                 out_valid,
  output logic [REQ_WIDTH-1:0] out_req,
  input  logic                 out_alm_full,
  output logic                 drop
`ifdef CCI_MPF_REQ_BUF_STATS_EN
  ,
  output logic [CW-1:0]        hwm,
  output logic [31:0]          stall_cycles
`endif
);

  logic [REQ_WIDTH-1:0] mem [N_ENTRIES];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 enq, deq;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign deq      = (count != '0) && !out_alm_full;
  assign enq      = in_valid && ((count != CW'(N_ENTRIES)) || deq);
  assign drop     = in_valid && !enq;
  assign alm_full = (count >= CW'(N_ENTRIES - ALM_FULL_THRESHOLD));

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_req   <= '0;
    end else begin
      out_valid <= deq;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) begin
        out_req <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef CCI_MPF_REQ_BUF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hwm          <= '0;
      stall_cycles <= '0;
    end else begin
      if (count > hwm) hwm <= count;
      if ((count != '0) && out_alm_full && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

module cci_mpf_shim_req_buffer #(
  parameter int N_ENTRIES          = 8,
  parameter int ALM_FULL_THRESHOLD = 4,
  parameter int C0_REQ_WIDTH       = 80,
  parameter int C1_REQ_WIDTH       = 592,
  localparam int CW = $clog2(N_ENTRIES) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    afu_c0_valid,
  input  logic [C0_REQ_WIDTH-1:0] afu_c0_req,
  output logic                    afu_c0_alm_full,
  input  logic                    afu_c1_valid,
  input  logic [C1_REQ_WIDTH-1:0] afu_c1_req,
  output logic                    afu_c1_alm_full,
  output logic                    fiu_c0_valid,
  output logic [C0_REQ_WIDTH-1:0] fiu_c0_req,
  input  logic                    fiu_c0_alm_full,
  output logic                    fiu_c1_valid,
  output logic [C1_REQ_WIDTH-1:0] fiu_c1_req,
  input  logic                    fiu_c1_alm_full,
  output logic                    overflow
`ifdef CCI_MPF_REQ_BUF_STATS_EN
  ,
  output logic [CW-1:0]           c0_hwm,
  output logic [CW-1:0]           c1_hwm,
  output logic [31:0]             c0_stall_cycles,
  output logic [31:0]             c1_stall_cycles
`endif
);

  logic drop0, drop1;

  cci_mpf_shim_req_buffer_chan #(
    .N_ENTRIES(N_ENTRIES), .ALM_FULL_THRESHOLD(ALM_FULL_THRESHOLD), .REQ_WIDTH(C0_REQ_WIDTH)
  ) u_c0 (
    .clk(clk), .reset(reset),
    .in_valid(afu_c0_valid), .in_req(afu_c0_req), .alm_full(afu_c0_alm_full),
    .out_valid(fiu_c0_valid), .out_req(fiu_c0_req), .out_alm_full(fiu_c0_alm_full),
    .drop(drop0)
`ifdef CCI_MPF_REQ_BUF_STATS_EN
    , .hwm(c0_hwm), .stall_cycles(c0_stall_cycles)
`endif
  );

  cci_mpf_shim_req_buffer_chan #(
    .N_ENTRIES(N_ENTRIES), .ALM_FULL_THRESHOLD(ALM_FULL_THRESHOLD), .REQ_WIDTH(C1_REQ_WIDTH)
  ) u_c1 (
    .clk(clk), .reset(reset),
    .in_valid(afu_c1_valid), .in_req(afu_c1_req), .alm_full(afu_c1_alm_full),
    .out_valid(fiu_c1_valid), .out_req(fiu_c1_req), .out_alm_full(fiu_c1_alm_full),
    .drop(drop1)
`ifdef CCI_MPF_REQ_BUF_STATS_EN
    , .hwm(c1_hwm), .stall_cycles(c1_stall_cycles)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else       overflow <= overflow | drop0 | drop1;
  end

endmodule

// File: doc/cci_mpf_shim_req_buffer.md
Name: cci_mpf_shim_req_buffer

Overview:
- Request-side elastic buffer between the response-ordering/Mdata shim (AFU side) and the FIU.
- Absorbs read (c0) and write (c1) requests that the AFU may legally issue after almost-full asserts, then drains them toward the FIU only while the FIU's almost-full is low.
- Decouples AFU-visible almost-full from FIU almost-full and registers all FIU-bound request outputs.
- One FIFO per channel, with a per-channel occupancy counter.

Parameters:
- N_ENTRIES, 8: FIFO depth per channel; power of 2; must be > ALM_FULL_THRESHOLD.
- ALM_FULL_THRESHOLD, 4: minimum free slots guaranteed after afu almost-full asserts (CCI almost-full semantics).
- C0_REQ_WIDTH, 80: packed c0 request (header) width.
- C1_REQ_WIDTH, 592: packed c1 request (header + 512b data) width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- afu_c0_valid  in  1  read request valid
- afu_c0_req  in  C0_REQ_WIDTH  read request
- afu_c0_alm_full  out  1  read channel almost full, to AFU side
- afu_c1_valid  in  1  write request valid
- afu_c1_req  in  C1_REQ_WIDTH  write request
- afu_c1_alm_full  out  1  write channel almost full, to AFU side
- fiu_c0_valid  out  1  read request valid, to FIU
- fiu_c0_req  out  C0_REQ_WIDTH  registered read request
- fiu_c0_alm_full  in  1  FIU read almost full
- fiu_c1_valid  out  1  write request valid, to FIU
- fiu_c1_req  out  C1_REQ_WIDTH  registered write request
- fiu_c1_alm_full  in  1  FIU write almost full
- overflow  out  1  sticky: a request arrived with its FIFO full and was dropped

Behaviour:
- Reset (async, active-high):
  - Counts, read/write pointers, fiu_c*_valid and overflow go to 0.
  - fiu_c*_req go to 0.
  - afu_c*_alm_full evaluate to 0 (counts are 0).
  - Reset mid-operation discards all buffered requests; nothing is replayed.
- Channels are fully independent and identical; the rules below are per channel x.
- Enqueue:
  - afu_cx_valid=1 with count<N_ENTRIES writes the request at wr_ptr and increments wr_ptr modulo N_ENTRIES.
  - Enqueue at count==N_ENTRIES is accepted only if a dequeue occurs in the same cycle.
  - Otherwise the request is dropped and overflow is set, remaining set until reset.
- Dequeue:
  - Occurs in a cycle when count>0 and fiu_cx_alm_full=0, sampled that same cycle.
  - The head entry is loaded into the fiu_cx_req register, fiu_cx_valid=1 on the next edge, and rd_ptr increments modulo N_ENTRIES.
  - When no dequeue occurs, fiu_cx_valid=0 next cycle and fiu_cx_req holds its value.
  - At most one request per channel per cycle.
- Latency: request enqueued at edge t (buffer previously empty, FIU not almost full) appears on fiu_cx_valid at edge t+1; minimum 1 cycle, no combinational bypass.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both or neither: unchanged.
  - Width is clog2(N_ENTRIES)+1 bits; never exceeds N_ENTRIES.
- afu_cx_alm_full = (count >= N_ENTRIES - ALM_FULL_THRESHOLD), combinational from registered count. It does not depend on fiu_cx_alm_full.
- Ordering: strict FIFO within a channel; no ordering between channels.
- Empty with fiu_cx_alm_full=0: fiu_cx_valid stays 0.
- Pointer wrap: N_ENTRIES-1 -> 0.

Optional Feature:
- Macro: CCI_MPF_REQ_BUF_STATS_EN.
- When defined, adds outputs:
  - c0_hwm and c1_hwm (clog2(N_ENTRIES)+1 bits): per-channel occupancy high-water marks, updated each cycle to max(hwm, count); reset to 0.
  - c0_stall_cycles and c1_stall_cycles (32b, saturating at 0xFFFFFFFF): count cycles with count>0 and fiu_cx_alm_full=1; reset to 0.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Single read: after reset, afu_c0_valid=1 with req=0x1234 for 1 cycle, FIU alm_full=0 -> fiu_c0_valid=1 with req=0x1234 exactly one cycle later; count returns to 0; afu_c0_alm_full stays 0.
- Almost-full threshold: fiu_c1_alm_full=1, afu writes on 4 consecutive cycles -> afu_c1_alm_full=1 after 4th enqueue (count=4); 4 more writes accepted (count=8); overflow=0.
- Overflow: with count=8 and fiu_c1_alm_full=1, one more write -> dropped; overflow=1 and stays 1 until reset; count stays 8.
- Drain order/wrap: enqueue values 0..11 on c0 while draining with fiu_c0_alm_full toggled 1,0 every cycle -> outputs 0..11 in order, pointers wrap, never more than one fiu_c0_valid per cycle.
- Full plus simultaneous enq/deq: count=8, fiu_c0_alm_full=0, afu_c0_valid=1 -> accepted, count stays 8, overflow=0.
- Async reset mid-stream: assert reset with count=5 between clock edges -> fiu_c0_valid and count go to 0 immediately; after release, no stale requests are emitted.
